var_driver: RTL and testbench
=============================

Name: var_driver

Overview:
- Event-to-code driver for the thermostat house controller.
- Watches seven single-bit, clk-synchronous event inputs and detects their rising edges.
- On each accepted event it latches a 4-bit event code on out_var and emits a one-cycle class strobe: hitC_var for comfort/climate events, hitM_var for manual events.
- Gated by run and by an internal mode FSM; downstream controller logic consumes out_var and the strobes.

Parameters:
- none (code width fixed at 4 bits; codes are package constants)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  global enable; 0 = block frozen
- start  in  1  start request (event, rising edge)
- confM  in  1  manual-configuration confirm (event)
- al  in  1  alarm (event on rise; level holds alarm mode)
- wsc  in  1  window sensor, comfort zone (event)
- wsm  in  1  window sensor, manual zone (event)
- ss  in  1  set-season request (event)
- st  in  1  set-temperature request (event)
- hitC_var  out  1  one-cycle strobe: C-class code loaded
- hitM_var  out  1  one-cycle strobe: M-class code loaded
- out_var  out  4  last accepted event code

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values: out_var=4'h0, hitC_var=0, hitM_var=0, FSM=STOP, all edge-history registers=0, return register=IDLE.
- Codes: NONE=0x0, START=0x1, CONFM=0x2, ALARM=0x3, SS=0x4, ST=0x5, WSC=0x6, WSM=0x7. Codes 0x8-0xF are never produced.
- Classes: C = START, SS, ST, WSC; M = CONFM, WSM; ALARM pulses both hitC_var and hitM_var.
- Edge detect:
  - Per input x: rise_x = x & ~x_prev.
  - x_prev updates every cycle, including when run=0. An input already high when run rises therefore produces no event.
  - After reset, x_prev=0, so an input high at the first cycle out of reset counts as a rise.
- Latency:
  - A rise sampled at clk edge k updates out_var and the strobe at edge k, visible in cycle k+1.
  - Strobes are high for exactly one cycle; out_var holds until the next accepted event.
- FSM states: STOP, IDLE, ACTIVE, ALARM.
  - STOP: all events ignored; out_var holds; strobes 0. Goes to IDLE when run=1.
  - IDLE: accepts start (load START, go to ACTIVE), confM (load CONFM, stay) and al (load ALARM, return:=IDLE, go to ALARM). ss, st, wsc and wsm are ignored.
  - ACTIVE: accepts all events. al loads ALARM, sets return:=ACTIVE and goes to ALARM; every other event loads its code and stays in ACTIVE. A start rise in ACTIVE reloads START.
  - ALARM: out_var=ALARM; all other events ignored. When al=0, go to the return state; out_var holds ALARM and no strobe is issued on exit.
  - Any state with run=0 goes to STOP next cycle, with no event accepted that cycle.
  - On later run=1, resume from IDLE (ACTIVE context lost).
- Simultaneous rises in one cycle:
  - Accept only the highest priority allowed in the current state: al > confM > start > wsm > wsc > st > ss.
  - The others are dropped, not queued.
- rst has priority over run and over all events.

Decomposition:
- Package var_driver_pkg: 4-bit event code localparams, the FSM state enum (2 bits), and a class-decode function (code -> {isC, isM}).
- One sub-module is natural: edge_det (1-bit rise detector with prev register), instantiated 7 times.
- FSM, priority encoder and output registers stay in var_driver.

Test Plan:
- Reset 5 cycles with run=0; pulse start → out_var=0x0, strobes 0, FSM stays STOP.
- run=1, confM pulse → one cycle later out_var=0x2 and hitM_var=1 for 1 cycle. Then ss pulse in IDLE → out_var stays 0x2, no strobe.
- run=1, start pulse → out_var=0x1, hitC_var 1 cycle. Then ss, then st → out_var=0x4, then 0x5, each with a single hitC_var. Then wsm → 0x7 with hitM_var.
- From ACTIVE, al high for 4 cycles with ss pulsed meanwhile:
  - out_var=0x3 with hitC_var and hitM_var both high 1 cycle; ss ignored.
  - After al falls, an st pulse gives out_var=0x5 (returned to ACTIVE).
- Same-cycle rise of al, start and wsc in ACTIVE → out_var=0x3 only. Same-cycle wsc and ss → out_var=0x6.
- Other checks:
  - run=0 mid-ACTIVE, then pulse all inputs → out_var holds last code, no strobes.
  - rst asserted while in ALARM → out_var=0x0 next cycle, FSM STOP.

Source files
------------

// File: rtl/var_driver_pkg.sv
// -----------------------------------------------------------------------------
// var_driver_pkg
// Shared definitions for the thermostat event-to-code driver:
//   - 4-bit event codes loaded onto out_var
//   - mode FSM state encoding (2 bits)
//   - code_class(): maps an event code to its {isC, isM} strobe pair
// -----------------------------------------------------------------------------
package var_driver_pkg;

    localparam logic [3:0] CODE_NONE  = 4'h0;
    localparam logic [3:0] CODE_START = 4'h1;
    localparam logic [3:0] CODE_CONFM = 4'h2;
    localparam logic [3:0] CODE_ALARM = 4'h3;
    localparam logic [3:0] CODE_SS    = 4'h4;
    localparam logic [3:0] CODE_ST    = 4'h5;
    localparam logic [3:0] CODE_WSC   = 4'h6;
    localparam logic [3:0] CODE_WSM   = 4'h7;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    // Returns {isC, isM}. ALARM belongs to both classes so both strobes fire.
    function automatic logic [1:0] code_class(input logic [3:0] code);
        logic [1:0] cls;
        cls = 2'b00;
        case (code)
            CODE_START, CODE_SS, CODE_ST, CODE_WSC: cls = 2'b10;
            CODE_CONFM, CODE_WSM:                   cls = 2'b01;
            CODE_ALARM:                             cls = 2'b11;
            default:                                cls = 2'b00;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/var_driver_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Single-bit rising-edge detector for a clk-synchronous input.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, clears the history register
//   x    - monitored input
//   rise - combinational, high in the cycle where x=1 and the previous x=0
// The history register updates every cycle regardless of any enable, so a
// level that was already high when the consumer wakes up is not an edge.
// -----------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic rise
);

    logic prev;

    // Track the input from the previous cycle; cleared to 0 on reset so an
    // input high right after reset is seen as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= x;
        end
    end

    assign rise = x & ~prev;

endmodule

// File: rtl/var_driver.sv
// -----------------------------------------------------------------------------
// var_driver
// Event-to-code driver for the thermostat house controller. Detects rising
// edges on seven event inputs, selects the highest-priority event allowed in
// the current mode, latches its code and pulses the class strobe(s).
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   run                 - global enable; 0 forces the mode FSM to STOP
//   start, confM, al,
//   wsc, wsm, ss, st    - event inputs (rising edge = event; al level also
//                         holds alarm mode)
//   hitC_var, hitM_var  - one-cycle strobes for C-class / M-class codes
//   out_var             - last accepted event code
// -----------------------------------------------------------------------------
module var_driver
    import var_driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       start,
    input  logic       confM,
    input  logic       al,
    input  logic       wsc,
    input  logic       wsm,
    input  logic       ss,
    input  logic       st,
    output logic       hitC_var,
    output logic       hitM_var,
    output logic [3:0] out_var
);

    logic rise_start, rise_confM, rise_al, rise_wsc, rise_wsm, rise_ss, rise_st;

    edge_det u_ed_start (.clk(clk), .rst(rst), .x(start), .rise(rise_start));
    edge_det u_ed_confM (.clk(clk), .rst(rst), .x(confM), .rise(rise_confM));
    edge_det u_ed_al    (.clk(clk), .rst(rst), .x(al),    .rise(rise_al));
    edge_det u_ed_wsc   (.clk(clk), .rst(rst), .x(wsc),   .rise(rise_wsc));
    edge_det u_ed_wsm   (.clk(clk), .rst(rst), .x(wsm),   .rise(rise_wsm));
    edge_det u_ed_ss    (.clk(clk), .rst(rst), .x(ss),    .rise(rise_ss));
    edge_det u_ed_st    (.clk(clk), .rst(rst), .x(st),    .rise(rise_st));

    state_t     state;
    state_t     ret_state;
    logic       sel_valid;
    logic [3:0] sel_code;
    logic [1:0] sel_class;

    // Priority encoder: al > confM > start > wsm > wsc > st > ss. IDLE only
    // listens to the first three; the zone/season/temperature events need
    // ACTIVE. Lower-priority rises in the same cycle are simply dropped.
    always_comb begin
        sel_valid = 1'b0;
        sel_code  = CODE_NONE;
        if (state == ST_IDLE || state == ST_ACTIVE) begin
            if (rise_al) begin
                sel_valid = 1'b1;
                sel_code  = CODE_ALARM;
            end else if (rise_confM) begin
                sel_valid = 1'b1;
                sel_code  = CODE_CONFM;
            end else if (rise_start) begin
                sel_valid = 1'b1;
                sel_code  = CODE_START;
            end else if (state == ST_ACTIVE) begin
                if (rise_wsm) begin
                    sel_valid = 1'b1;
                    sel_code  = CODE_WSM;
                end else if (rise_wsc) begin
                    sel_valid = 1'b1;
                    sel_code  = CODE_WSC;
                end else if (rise_st) begin
                    sel_valid = 1'b1;
                    sel_code  = CODE_ST;
                end else if (rise_ss) begin
                    sel_valid = 1'b1;
                    sel_code  = CODE_SS;
                end
            end
        end
    end

    assign sel_class = code_class(sel_code);

    // Mode FSM with registered code and strobes. run=0 wins over any event
    // in the same cycle. Leaving ALARM restores the saved mode without
    // reloading a code or pulsing a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            ret_state <= ST_IDLE;
            out_var   <= CODE_NONE;
            hitC_var  <= 1'b0;
            hitM_var  <= 1'b0;
        end else begin
            hitC_var <= 1'b0;
            hitM_var <= 1'b0;
            if (!run) begin
                state <= ST_STOP;
            end else begin
                case (state)
                    ST_STOP: begin
                        state <= ST_IDLE;
                    end
                    ST_IDLE, ST_ACTIVE: begin
                        if (sel_valid) begin
                            out_var  <= sel_code;
                            hitC_var <= sel_class[1];
                            hitM_var <= sel_class[0];
                            if (sel_code == CODE_ALARM) begin
                                ret_state <= state;
                                state     <= ST_ALARM;
                            end else if (sel_code == CODE_START) begin
                                state <= ST_ACTIVE;
                            end
                        end
                    end
                    ST_ALARM: begin
                        if (!al) begin
                            state <= ret_state;
                        end
                    end
                    default: begin
                        state <= ST_STOP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_var_driver.sv
// -----------------------------------------------------------------------------
// tb_var_driver
// Directed bench for var_driver. Each stimulus that should produce an event
// pushes its expected {code, hitC, hitM} into a scoreboard queue; a monitor
// pops and compares whenever the DUT raises a strobe. Direct out_var checks
// cover ignored events, reset and hold behaviour.
// -----------------------------------------------------------------------------
module tb_var_driver;

    typedef struct packed {
        logic [3:0] code;
        logic       c;
        logic       m;
    } exp_t;

    // Input mask order: {al, confM, start, wsm, wsc, st, ss}
    localparam logic [6:0] M_AL    = 7'b1000000;
    localparam logic [6:0] M_CONFM = 7'b0100000;
    localparam logic [6:0] M_START = 7'b0010000;
    localparam logic [6:0] M_WSM   = 7'b0001000;
    localparam logic [6:0] M_WSC   = 7'b0000100;
    localparam logic [6:0] M_ST    = 7'b0000010;
    localparam logic [6:0] M_SS    = 7'b0000001;
    localparam logic [6:0] M_ALL   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       start = 1'b0, confM = 1'b0, al = 1'b0, wsc = 1'b0;
    logic       wsm = 1'b0, ss = 1'b0, st = 1'b0;
    logic       hitC_var, hitM_var;
    logic [3:0] out_var;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    var_driver dut (
        .clk(clk), .rst(rst), .run(run),
        .start(start), .confM(confM), .al(al), .wsc(wsc),
        .wsm(wsm), .ss(ss), .st(st),
        .hitC_var(hitC_var), .hitM_var(hitM_var), .out_var(out_var)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Monitor: every strobe cycle must match the oldest expected event;
    // a strobe with nothing expected (ignored event, stretched strobe) fails.
    always @(negedge clk) begin
        exp_t e;
        if (hitC_var || hitM_var) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got code=%h c=%b m=%b, required no strobe",
                         out_var, hitC_var, hitM_var);
            end else begin
                e = sb.pop_front();
                if (out_var !== e.code || hitC_var !== e.c || hitM_var !== e.m) begin
                    errors++;
                    $display("[TB] FAIL event: got code=%h c=%b m=%b, required code=%h c=%b m=%b",
                             out_var, hitC_var, hitM_var, e.code, e.c, e.m);
                end
            end
        end
    end

    task automatic setInputs(input logic [6:0] v);
        {al, confM, start, wsm, wsc, st, ss} = v;
    endtask

    // One-cycle pulse on the masked inputs; returns on the negedge where the
    // resulting code/strobe is visible.
    task automatic applyStimulus(input logic [6:0] v);
        @(negedge clk);
        setInputs(v);
        @(negedge clk);
        setInputs(7'b0);
    endtask

    task automatic expectEvent(input logic [3:0] code, input logic c, input logic m);
        exp_t e;
        e.code = code;
        e.c    = c;
        e.m    = m;
        sb.push_back(e);
    endtask

    // Checks out_var and that no expected strobe is still outstanding.
    task automatic checkOutput(input string name, input logic [3:0] code);
        #1;
        checks++;
        if (out_var !== code) begin
            errors++;
            $display("[TB] FAIL %s: out_var=%h, required %h", name, out_var, code);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending: %0d expected events not seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic checkQuiet(input string name, input logic [3:0] code);
        #1;
        checks++;
        if (out_var !== code || hitC_var !== 1'b0 || hitM_var !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: code=%h c=%b m=%b, required code=%h c=0 m=0",
                     name, out_var, hitC_var, hitM_var, code);
        end
    endtask

    initial begin
        // Reset with run=0
        repeat (5) @(negedge clk);
        checkQuiet("reset_state", 4'h0);
        rst = 1'b0;
        applyStimulus(M_START);
        checkOutput("stop_ignores_start", 4'h0);

        // Enable: STOP -> IDLE
        @(negedge clk);
        run = 1'b1;
        expectEvent(4'h2, 1'b0, 1'b1);
        applyStimulus(M_CONFM);
        checkOutput("idle_confM", 4'h2);
        applyStimulus(M_SS);
        checkOutput("idle_ignores_ss", 4'h2);

        // IDLE -> ACTIVE, then C/M events
        expectEvent(4'h1, 1'b1, 1'b0);
        applyStimulus(M_START);
        checkOutput("start", 4'h1);
        expectEvent(4'h4, 1'b1, 1'b0);
        applyStimulus(M_SS);
        checkOutput("active_ss", 4'h4);
        expectEvent(4'h5, 1'b1, 1'b0);
        applyStimulus(M_ST);
        checkOutput("active_st", 4'h5);
        expectEvent(4'h7, 1'b0, 1'b1);
        applyStimulus(M_WSM);
        checkOutput("active_wsm", 4'h7);

        // al held 4 cycles with an ss pulse inside; ss must be ignored
        expectEvent(4'h3, 1'b1, 1'b1);
        @(negedge clk);
        setInputs(M_AL);
        @(negedge clk);
        setInputs(M_AL | M_SS);
        @(negedge clk);
        setInputs(M_AL);
        @(negedge clk);
        setInputs(M_AL);
        @(negedge clk);
        setInputs(7'b0);
        checkOutput("alarm_hold", 4'h3);
        expectEvent(4'h5, 1'b1, 1'b0);
        applyStimulus(M_ST);
        checkOutput("alarm_return_active", 4'h5);

        // Simultaneous rises
        expectEvent(4'h3, 1'b1, 1'b1);
        applyStimulus(M_AL | M_START | M_WSC);
        checkOutput("prio_al", 4'h3);
        expectEvent(4'h6, 1'b1, 1'b0);
        applyStimulus(M_WSC | M_SS);
        checkOutput("prio_wsc", 4'h6);

        // run=0 mid-ACTIVE: everything ignored, code held
        @(negedge clk);
        run = 1'b0;
        applyStimulus(M_ALL);
        checkOutput("run0_hold", 4'h6);
        applyStimulus(M_CONFM);
        checkQuiet("run0_quiet", 4'h6);

        // Re-enable resumes in IDLE, so ss is ignored
        @(negedge clk);
        run = 1'b1;
        applyStimulus(M_SS);
        checkOutput("resume_idle", 4'h6);

        // Enter ALARM from IDLE and reset while there
        expectEvent(4'h3, 1'b1, 1'b1);
        @(negedge clk);
        setInputs(M_AL);
        repeat (2) @(negedge clk);
        checkOutput("idle_alarm", 4'h3);
        rst = 1'b1;
        @(negedge clk);
        checkQuiet("reset_in_alarm", 4'h0);
        rst = 1'b0;
        @(negedge clk);
        setInputs(7'b0);
        checkOutput("after_reset_stop", 4'h0);
        expectEvent(4'h1, 1'b1, 1'b0);
        applyStimulus(M_START);
        checkOutput("after_reset_idle_start", 4'h1);

        repeat (3) @(negedge clk);
        checkOutput("final", 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
